// File: rtl/sram_arbiter_if.sv
// Bundle of the video port, host port and SRAM-side signals shared by the arbiter.
// The arbiter uses the slave view; requesters and the SRAM model use the master view.
interface sram_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_gnt;
    logic                  vid_rvalid;
    logic [DATA_WIDTH-1:0] vid_rdata;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic                  host_rvalid;
    logic [DATA_WIDTH-1:0] host_rdata;

    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    modport slave (
        input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, sram_rdata,
        output vid_gnt, vid_rvalid, vid_rdata, host_gnt, host_rvalid, host_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, sram_rdata,
        input  vid_gnt, vid_rvalid, vid_rdata, host_gnt, host_rvalid, host_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one synchronous-read SRAM between a priority video read port and a host
// read/write port; a starvation counter forces a host slot after STARVE_LIMIT denials.
module sram_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    sram_arbiter_if.slave bus
);
    localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]            r_wait_cnt;
    logic                  r_sram_en;
    logic                  r_sram_we;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [DATA_WIDTH-1:0] r_sram_wdata;
    logic [1:0]            r_tag1;
    logic [1:0]            r_tag2;
    logic                  w_host_gnt;
    logic                  w_vid_gnt;
    logic                  w_xfer;

    // Requests are masked while reset is held so no grant can leak out.
    always_comb begin
        w_host_gnt = reset_n && bus.host_req && (!bus.vid_req || (r_wait_cnt == LP_STARVE_LIMIT));
        w_vid_gnt  = reset_n && bus.vid_req && !w_host_gnt;
        w_xfer     = w_host_gnt || w_vid_gnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= 8'd0;
        end else if (!bus.host_req || w_host_gnt) begin
            r_wait_cnt <= 8'd0;
        end else if (r_wait_cnt != LP_STARVE_LIMIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_sram_en <= w_xfer;
            r_sram_we <= w_host_gnt && bus.host_we;
            if (w_host_gnt) begin
                r_sram_addr  <= bus.host_addr;
                r_sram_wdata <= bus.host_wdata;
            end else if (w_vid_gnt) begin
                r_sram_addr  <= bus.vid_addr;
            end
        end
    end

    // Tag bits {video, host read} follow each read through the SRAM's one-cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag1 <= 2'b00;
            r_tag2 <= 2'b00;
        end else begin
            r_tag1 <= {w_vid_gnt, w_host_gnt && !bus.host_we};
            r_tag2 <= r_tag1;
        end
    end

    assign bus.vid_gnt     = w_vid_gnt;
    assign bus.host_gnt    = w_host_gnt;
    assign bus.vid_rvalid  = r_tag2[1];
    assign bus.host_rvalid = r_tag2[0];
    assign bus.vid_rdata   = bus.sram_rdata;
    assign bus.host_rdata  = bus.sram_rdata;
    assign bus.sram_en     = r_sram_en;
    assign bus.sram_we     = r_sram_we;
    assign bus.sram_addr   = r_sram_addr;
    assign bus.sram_wdata  = r_sram_wdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a request-level model predicts grants, SRAM issue and
// read returns every cycle, and directed scenarios pin a few hand-computed values.
module tb_sram_arbiter;
    localparam int STARVE = 4;

    typedef struct {
        int         due;
        bit         isVid;
        logic [7:0] data;
    } ret_t;

    logic clk;
    logic reset_n;

    sram_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .STARVE_LIMIT(STARVE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] sram   [0:65535];
    logic [7:0] refMem [0:65535];
    ret_t       pend[$];
    logic [7:0] vidSeen[$];
    logic [7:0] hostSeen[$];
    int         vidCyc[$];
    int         hostCyc[$];
    int         modelCyc   = 0;
    int         hostWait   = 0;
    int         assertCount = 0;
    int         failCount   = 0;
    logic        expEn, expWe;
    logic [15:0] expAddr;
    logic [7:0]  expWdata;

    function automatic logic [7:0] pattern(input int a);
        logic [15:0] v;
        v = 16'(a);
        return v[7:0] ^ v[15:8] ^ 8'h3C;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, modelCyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous SRAM: one-cycle read latency, echoes write data on a write.
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) begin
                sram[bus.sram_addr] <= bus.sram_wdata;
                bus.sram_rdata      <= bus.sram_wdata;
            end else begin
                bus.sram_rdata <= sram[bus.sram_addr];
            end
        end
    end

    // Request-level model: the host may wait at most STARVE denied cycles, reads return
    // two edges after their handshake with the memory contents seen in issue order.
    always @(negedge clk) begin : compareBlk
        logic       eHost, eVid, eVr, eHr;
        logic [7:0] eData;
        if (!reset_n) begin
            checkOutput("rst_vid_gnt", bus.vid_gnt, 0);
            checkOutput("rst_host_gnt", bus.host_gnt, 0);
            checkOutput("rst_sram_en", bus.sram_en, 0);
            checkOutput("rst_sram_we", bus.sram_we, 0);
            checkOutput("rst_sram_addr", bus.sram_addr, 0);
            checkOutput("rst_sram_wdata", bus.sram_wdata, 0);
            checkOutput("rst_vid_rvalid", bus.vid_rvalid, 0);
            checkOutput("rst_host_rvalid", bus.host_rvalid, 0);
            hostWait = 0;
            pend.delete();
            expEn = 0; expWe = 0; expAddr = 0; expWdata = 0;
        end else begin
            eHost = bus.host_req && (!bus.vid_req || hostWait >= STARVE);
            eVid  = bus.vid_req && !eHost;
            checkOutput("host_gnt", bus.host_gnt, eHost);
            checkOutput("vid_gnt", bus.vid_gnt, eVid);
            checkOutput("sram_en", bus.sram_en, expEn);
            checkOutput("sram_we", bus.sram_we, expWe);
            checkOutput("sram_addr", bus.sram_addr, expAddr);
            if (expWe) checkOutput("sram_wdata", bus.sram_wdata, expWdata);

            eVr = 0; eHr = 0; eData = 0;
            if (pend.size() > 0 && pend[0].due == modelCyc) begin
                eVr   = pend[0].isVid;
                eHr   = !pend[0].isVid;
                eData = pend[0].data;
                void'(pend.pop_front());
            end
            checkOutput("vid_rvalid", bus.vid_rvalid, eVr);
            checkOutput("host_rvalid", bus.host_rvalid, eHr);
            if (eVr) checkOutput("vid_rdata", bus.vid_rdata, eData);
            if (eHr) checkOutput("host_rdata", bus.host_rdata, eData);
            if (bus.vid_rvalid) begin vidSeen.push_back(bus.vid_rdata); vidCyc.push_back(modelCyc); end
            if (bus.host_rvalid) begin hostSeen.push_back(bus.host_rdata); hostCyc.push_back(modelCyc); end

            if (eHost || !bus.host_req) hostWait = 0;
            else hostWait++;
            expEn = eHost || eVid;
            expWe = eHost && bus.host_we;
            if (eHost) begin
                expAddr  = bus.host_addr;
                expWdata = bus.host_wdata;
                if (bus.host_we) refMem[bus.host_addr] = bus.host_wdata;
                else pend.push_back('{modelCyc + 2, 1'b0, refMem[bus.host_addr]});
            end else if (eVid) begin
                expAddr = bus.vid_addr;
                pend.push_back('{modelCyc + 2, 1'b1, refMem[bus.vid_addr]});
            end
        end
        modelCyc++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one host request, waits (bounded) for its grant and returns just after the transfer edge.
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
        int n;
        n = 0;
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
        @(negedge clk);
        while (!bus.host_gnt && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("host_gnt_wait", (n < 20) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        bus.host_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram[i]   = pattern(i);
            refMem[i] = pattern(i);
        end
        reset_n        = 1'b0;
        bus.vid_req    = 1'b1;
        bus.vid_addr   = 16'h0000;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b0;
        bus.host_addr  = 16'h0000;
        bus.host_wdata = 8'h00;
        bus.sram_rdata = 8'h00;

        // Reset held with both requests up, then released: video is granted at once.
        repeat (3) @(negedge clk);
        checkOutput("reset_vid_gnt", bus.vid_gnt, 0);
        checkOutput("reset_host_gnt", bus.host_gnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("release_vid_gnt", bus.vid_gnt, 1);
        checkOutput("release_host_gnt", bus.host_gnt, 0);
        @(posedge clk);
        #1;
        bus.vid_req  = 1'b0;
        bus.host_req = 1'b0;
        idle(3);

        // Host write then read-after-write of the same address.
        hostSeen.delete();
        applyStimulus(1'b1, 16'h0010, 8'hA5);
        applyStimulus(1'b0, 16'h0010, 8'h00);
        @(negedge clk);
        checkOutput("raw_early_rvalid", bus.host_rvalid, 0);
        @(negedge clk);
        checkOutput("raw_rvalid", bus.host_rvalid, 1);
        checkOutput("raw_rdata", bus.host_rdata, 8'hA5);
        idle(3);
        checkOutput("raw_rvalid_count", hostSeen.size(), 1);

        // Video stream over addresses 0..3, advancing on each grant.
        vidSeen.delete();
        vidCyc.delete();
        bus.vid_req  = 1'b1;
        bus.vid_addr = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stream_vid_gnt", bus.vid_gnt, 1);
            @(posedge clk);
            #1;
            bus.vid_addr = 16'(i + 1);
        end
        bus.vid_req = 1'b0;
        idle(4);
        checkOutput("stream_count", vidSeen.size(), 4);
        if (vidSeen.size() == 4) begin
            checkOutput("stream_d0", vidSeen[0], 8'h3C);
            checkOutput("stream_d1", vidSeen[1], 8'h3D);
            checkOutput("stream_d2", vidSeen[2], 8'h3E);
            checkOutput("stream_d3", vidSeen[3], 8'h3F);
            checkOutput("stream_back_to_back", vidCyc[3] - vidCyc[0], 3);
        end

        // Starvation: both requests held, host must win exactly every fifth cycle.
        bus.vid_req   = 1'b1;
        bus.vid_addr  = 16'h0005;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 16'h0007;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checkOutput("starve_host_gnt", bus.host_gnt, (i % 5 == 4) ? 1 : 0);
            checkOutput("starve_vid_gnt", bus.vid_gnt, (i % 5 == 4) ? 0 : 1);
        end
        @(posedge clk);
        #1;
        bus.vid_req  = 1'b0;
        bus.host_req = 1'b0;
        idle(4);

        // Mixed: video read 0x0100 then host read 0x0200 on consecutive cycles.
        vidSeen.delete(); vidCyc.delete();
        hostSeen.delete(); hostCyc.delete();
        bus.vid_req  = 1'b1;
        bus.vid_addr = 16'h0100;
        @(negedge clk);
        checkOutput("mixed_vid_gnt", bus.vid_gnt, 1);
        @(posedge clk);
        #1;
        bus.vid_req = 1'b0;
        applyStimulus(1'b0, 16'h0200, 8'h00);
        idle(4);
        checkOutput("mixed_vid_count", vidSeen.size(), 1);
        checkOutput("mixed_host_count", hostSeen.size(), 1);
        if (vidSeen.size() == 1 && hostSeen.size() == 1) begin
            checkOutput("mixed_vid_data", vidSeen[0], 8'h3D);
            checkOutput("mixed_host_data", hostSeen[0], 8'h3E);
            checkOutput("mixed_order", hostCyc[0] - vidCyc[0], 1);
        end

        // Reset right after a host read handshake: that read must never return.
        hostSeen.delete();
        applyStimulus(1'b0, 16'h0030, 8'h00);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(4);
        checkOutput("flight_no_rvalid", hostSeen.size(), 0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares one single-port, synchronous-read SRAM between a video read port and a host read/write port. It sits between the VGA pixel fetcher, the host/animation logic and the image SRAM. It owns all SRAM control signals and returns read data to the port that issued the read. Video has priority; a starvation counter guarantees the host port a slot.

## Interface
- DATA_WIDTH, 8, SRAM word width
- ADDR_WIDTH, 16, SRAM address width
- STARVE_LIMIT, 4, consecutive denied host cycles before host is forced to win (1..255)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request
- vid_addr  in  ADDR_WIDTH  video read address
- vid_gnt  out  1  video request accepted this cycle (combinational)
- vid_rvalid  out  1  vid_rdata valid, one-cycle pulse
- vid_rdata  out  DATA_WIDTH  video read data
- host_req  in  1  host request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_gnt  out  1  host request accepted this cycle (combinational)
- host_rvalid  out  1  host_rdata valid, one-cycle pulse (reads only)
- host_rdata  out  DATA_WIDTH  host read data
- sram_en  out  1  SRAM enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM registered read data (1-cycle latency; returns write data on a write)

## Operation
- Handshake: a transfer occurs on a rising edge where req && gnt. Requesters hold req, addr, we and wdata stable until the transfer. Dropping req before it is granted is allowed and leaves no side effect.
- Grant rule, evaluated combinationally from the requests and wait_cnt:
  - host_gnt = host_req && (!vid_req || wait_cnt == STARVE_LIMIT)
  - vid_gnt = vid_req && !host_gnt
  - At most one grant per cycle.
- wait_cnt, 8 bits:
  - Reset to 0.
  - Cleared on a host transfer or when host_req is low.
  - Otherwise incremented on every edge where host_req && !host_gnt, saturating at STARVE_LIMIT.
- Issue register, updated on every edge:
  - On a transfer, sram_en = 1 and sram_addr / sram_we / sram_wdata come from the winner. sram_we = host_we for host and 0 for video.
  - With no transfer, sram_en = 0 and sram_we = 0. Addr and wdata hold their previous values.
- Return tag, 2 bits {vid, host_read}:
  - Stage 1 is registered at the transfer edge.
  - Stage 2 is registered on the next edge.
  - vid_rvalid and host_rvalid are the stage-2 bits.
- vid_rdata and host_rdata are driven directly from sram_rdata. They are meaningful only while the matching rvalid is high.
- Host writes generate no rvalid.

## Timing
- Reset values: sram_en, sram_we, vid_rvalid, host_rvalid, wait_cnt and all tags are 0. sram_addr and sram_wdata are 0.
- Grants are 0 while reset_n is low because requests are ignored during reset.
- Read latency: transfer at edge T, SRAM samples at edge T+1, rvalid and rdata valid in the cycle after T+1, i.e. 2 edges after the handshake.
- Write: transfer at edge T, SRAM written at edge T+1.
- Throughput: one transfer per cycle. Back-to-back reads from either port produce back-to-back rvalid pulses in issue order.
- Simultaneous requests with wait_cnt < STARVE_LIMIT: video wins.
- Continuous vid_req with continuous host_req: host is granted on the (STARVE_LIMIT+1)-th cycle of waiting. Video then wins the next cycle and the counter restarts from 0.
- Read-after-write to the same address issued on consecutive edges returns the new data, by SRAM ordering.
- Reset asserted mid-operation clears all tags at once. In-flight reads are discarded, no rvalid appears after reset, and a write issued but not yet sampled may be lost.

## Test plan
- Reset: hold reset_n = 0 with both reqs high -> both gnts 0, all outputs 0. Release -> first vid_gnt in the same cycle as vid_req.
- Host write then read: host write addr 0x0010 data 0xA5, then read 0x0010 -> host_rvalid exactly 2 edges after the read handshake, host_rdata = 0xA5, and no rvalid for the write.
- Video stream: vid_req held high with addr 0,1,2,3 advanced on each grant -> four consecutive vid_rvalid pulses carrying RAM[0..3] in order.
- Starvation, STARVE_LIMIT = 4, both reqs held high: 4 video grants, then 1 host grant, then video again, repeating 4:1 indefinitely. The host is never waiting more than 4 cycles.
- Mixed return: video read 0x0100 and host read 0x0200 on consecutive cycles -> vid_rvalid then host_rvalid on consecutive cycles, each with its own data and never both high.
- Reset mid-flight: assert reset_n low one edge after a read handshake -> no rvalid is ever produced for that read.
